i_mem_ctrl: RTL and testbench



---
 rtl/i_mem_ctrl_if.sv | 44 ++++
 rtl/i_mem_ctrl.sv | 177 +++++++++++++++++
 tb/tb_i_mem_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i_mem_ctrl_if.sv
// rtl/i_mem_ctrl_if.sv - fetch and program-load bus for i_mem_ctrl
// load_csum exists only when IMEM_LOAD_CSUM_EN is defined.
interface i_mem_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 128,
   parameter int ADDR_W = 32
);
   localparam int IDX_W = $clog2(DEPTH);

   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_gnt;
   logic              fetch_rvalid;
   logic [DATA_W-1:0] fetch_rdata;
   logic              fetch_err;
   logic              load_start;
   logic [IDX_W:0]    load_len;
   logic              load_valid;
   logic [DATA_W-1:0] load_data;
   logic              load_ready;
   logic              load_busy;
   logic              load_done;
`ifdef IMEM_LOAD_CSUM_EN
   logic [DATA_W-1:0] load_csum;
`endif

   modport master (
      output fetch_req, fetch_addr, load_start, load_len, load_valid, load_data,
      input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
      input  load_ready, load_busy, load_done
`ifdef IMEM_LOAD_CSUM_EN
      , input load_csum
`endif
   );

   modport slave (
      input  fetch_req, fetch_addr, load_start, load_len, load_valid, load_data,
      output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
      output load_ready, load_busy, load_done
`ifdef IMEM_LOAD_CSUM_EN
      , output load_csum
`endif
   );
endinterface

// File: rtl/i_mem_ctrl.sv
// rtl/i_mem_ctrl.sv - parametrised instruction memory with fetch pipeline and stream loader
// Optional running load checksum output enabled by IMEM_LOAD_CSUM_EN.
module i_mem_ctrl #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 128,
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   i_mem_ctrl_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W:0]   LEN_MAX = DEPTH[IDX_W:0];
   localparam logic [IDX_W:0]   LEN_ONE = 1;
   localparam logic [IDX_W-1:0] PTR_ONE = 1;

   typedef enum logic [0:0] {ST_RUN = 1'b0, ST_LOAD = 1'b1} state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [IDX_W:0]    r_len;
   logic [IDX_W-1:0]  r_ptr;
   logic              r_done;
   logic              r_s1_valid;
   logic              r_s1_err;
   logic [DATA_W-1:0] r_s1_data;

   logic              w_gnt;
   logic              w_load_ready;
   logic              w_load_busy;
   logic              w_wr;
   logic              w_last;
   logic              w_start;
   logic              w_start_zero;
   logic [IDX_W-1:0]  w_idx;
   logic              w_err;
   logic [IDX_W:0]    w_len_clamp;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_gnt        = 1'b0;
      w_load_ready = 1'b0;
      w_load_busy  = 1'b0;
      w_wr         = 1'b0;
      w_last       = 1'b0;
      w_start      = 1'b0;
      w_start_zero = 1'b0;
      case (r_state)
         ST_RUN: begin
            w_gnt = bus.fetch_req;
            if (bus.load_start) begin
               w_start = 1'b1;
               if (bus.load_len == '0) begin
                  w_start_zero = 1'b1;
               end else begin
                  w_state_nxt = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            w_load_ready = 1'b1;
            w_load_busy  = 1'b1;
            w_wr         = bus.load_valid;
            w_last       = bus.load_valid && ({1'b0, r_ptr} == (r_len - LEN_ONE));
            if (w_last) begin
               w_state_nxt = ST_RUN;
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   assign w_len_clamp = (bus.load_len > LEN_MAX) ? LEN_MAX : bus.load_len;

   // The pointer holds at len-1 on the final write, so a full-depth load never wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_len  <= '0;
         r_ptr  <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_start_zero | w_last;
         if (w_start) begin
            r_ptr <= '0;
            if (!w_start_zero) begin
               r_len <= w_len_clamp;
            end
         end else if (w_wr && !w_last) begin
            r_ptr <= r_ptr + PTR_ONE;
         end
      end
   end

   // Contents survive reset; a reset in the write cycle suppresses that write.
   always_ff @(posedge clk) begin
      if (w_wr && !rst) begin
         r_mem[r_ptr] <= bus.load_data;
      end
   end

   assign w_idx = bus.fetch_addr[IDX_W+1:2];
   assign w_err = (bus.fetch_addr[1:0] != 2'b00) || ((bus.fetch_addr >> (IDX_W + 2)) != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_err   <= 1'b0;
         r_s1_data  <= '0;
      end else begin
         r_s1_valid <= w_gnt;
         if (w_gnt) begin
            r_s1_err  <= w_err;
            r_s1_data <= w_err ? '0 : r_mem[w_idx];
         end
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic              r_s2_valid;
         logic              r_s2_err;
         logic [DATA_W-1:0] r_s2_data;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_s2_valid <= 1'b0;
               r_s2_err   <= 1'b0;
               r_s2_data  <= '0;
            end else begin
               r_s2_valid <= r_s1_valid;
               r_s2_err   <= r_s1_err;
               r_s2_data  <= r_s1_data;
            end
         end

         assign bus.fetch_rvalid = r_s2_valid;
         assign bus.fetch_err    = r_s2_err;
         assign bus.fetch_rdata  = r_s2_data;
      end else begin : g_lat1
         assign bus.fetch_rvalid = r_s1_valid;
         assign bus.fetch_err    = r_s1_err;
         assign bus.fetch_rdata  = r_s1_data;
      end
   endgenerate

`ifdef IMEM_LOAD_CSUM_EN
   logic [DATA_W-1:0] r_csum;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_csum <= '0;
      end else if (w_start) begin
         r_csum <= '0;
      end else if (w_wr) begin
         r_csum <= r_csum + bus.load_data;
      end
   end

   assign bus.load_csum = r_csum;
`endif

   assign bus.fetch_gnt  = w_gnt;
   assign bus.load_ready = w_load_ready;
   assign bus.load_busy  = w_load_busy;
   assign bus.load_done  = r_done;
endmodule

// File: tb/tb_i_mem_ctrl.sv
// tb/tb_i_mem_ctrl.sv - bench for i_mem_ctrl at RD_LAT=1 and RD_LAT=2 side by side
// Checks load_csum when IMEM_LOAD_CSUM_EN is defined.
module tb_i_mem_ctrl;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 128;
   localparam int ADDR_W = 32;
   localparam int IDX_W  = $clog2(DEPTH);

   logic              clk = 1'b0;
   logic              rst;
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              load_start;
   logic [IDX_W:0]    load_len;
   logic              load_valid;
   logic [DATA_W-1:0] load_data;

   always #5 clk = ~clk;

   i_mem_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus1 ();
   i_mem_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus2 ();

   assign bus1.fetch_req  = fetch_req;
   assign bus1.fetch_addr = fetch_addr;
   assign bus1.load_start = load_start;
   assign bus1.load_len   = load_len;
   assign bus1.load_valid = load_valid;
   assign bus1.load_data  = load_data;
   assign bus2.fetch_req  = fetch_req;
   assign bus2.fetch_addr = fetch_addr;
   assign bus2.load_start = load_start;
   assign bus2.load_len   = load_len;
   assign bus2.load_valid = load_valid;
   assign bus2.load_data  = load_data;

   i_mem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1));
   i_mem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(2)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2));

   typedef struct {
      int                due;
      bit                err;
      logic [DATA_W-1:0] data;
   } rsp_t;

   logic [DATA_W-1:0] m_mem [DEPTH];
   bit                m_loading = 1'b0;
   bit                m_done    = 1'b0;
   bit                m_live    = 1'b0;
   int                m_len, m_cnt;
   logic [DATA_W-1:0] m_csum = '0;
   rsp_t              q1[$];
   rsp_t              q2[$];
   int                cyc = 0;
   int                n_cmp = 0;
   int                n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rsp(input string tag, input bit have, input rsp_t r,
                          input logic v, input logic e, input logic [DATA_W-1:0] d);
      chk({tag, ".rvalid"}, 64'(v), 64'(have));
      if (have) begin
         chk({tag, ".err"}, 64'(e), 64'(r.err));
         chk({tag, ".rdata"}, 64'(d), 64'(r.data));
      end
   endtask

   // One clock: check combinational outputs, advance the model on the edge, check registered outputs.
   task automatic tick();
      rsp_t             r, r1, r2;
      bit               h1, h2;
      logic [IDX_W-1:0] widx;
      #1;
      if (m_live) begin
         chk("gnt1", 64'(bus1.fetch_gnt), 64'(!m_loading && fetch_req));
         chk("gnt2", 64'(bus2.fetch_gnt), 64'(!m_loading && fetch_req));
         chk("ready1", 64'(bus1.load_ready), 64'(m_loading));
         chk("busy1", 64'(bus1.load_busy), 64'(m_loading));
         chk("busy2", 64'(bus2.load_busy), 64'(m_loading));
      end
      @(posedge clk);
      if (rst) begin
         m_loading = 1'b0;
         m_done    = 1'b0;
         m_csum    = '0;
         m_live    = 1'b1;
         q1.delete();
         q2.delete();
      end else begin
         m_done = 1'b0;
         if (!m_loading && fetch_req) begin
            r.err  = (fetch_addr % 4 != 0) || (fetch_addr >= ADDR_W'(DEPTH * 4));
            widx   = fetch_addr[IDX_W+1:2];
            r.data = r.err ? '0 : m_mem[widx];
            r.due  = cyc + 1;
            q1.push_back(r);
            r.due  = cyc + 2;
            q2.push_back(r);
         end
         if (!m_loading) begin
            if (load_start) begin
               m_csum = '0;
               if (load_len == 0) begin
                  m_done = 1'b1;
               end else begin
                  m_loading = 1'b1;
                  m_len     = (int'(load_len) > DEPTH) ? DEPTH : int'(load_len);
                  m_cnt     = 0;
               end
            end
         end else if (load_valid) begin
            m_mem[m_cnt[IDX_W-1:0]] = load_data;
            m_csum = m_csum + load_data;
            m_cnt++;
            if (m_cnt == m_len) begin
               m_loading = 1'b0;
               m_done    = 1'b1;
            end
         end
      end
      cyc++;
      #1;
      h1 = (q1.size() > 0) && (q1[0].due == cyc);
      h2 = (q2.size() > 0) && (q2[0].due == cyc);
      r1 = '{due: 0, err: 1'b0, data: '0};
      r2 = '{due: 0, err: 1'b0, data: '0};
      if (h1) r1 = q1.pop_front();
      if (h2) r2 = q2.pop_front();
      chk_rsp("rsp1", h1, r1, bus1.fetch_rvalid, bus1.fetch_err, bus1.fetch_rdata);
      chk_rsp("rsp2", h2, r2, bus2.fetch_rvalid, bus2.fetch_err, bus2.fetch_rdata);
      chk("done1", 64'(bus1.load_done), 64'(m_done));
      chk("done2", 64'(bus2.load_done), 64'(m_done));
`ifdef IMEM_LOAD_CSUM_EN
      chk("csum1", 64'(bus1.load_csum), 64'(m_csum));
      chk("csum2", 64'(bus2.load_csum), 64'(m_csum));
`endif
   endtask

   task automatic idle();
      fetch_req  = 1'b0;
      fetch_addr = '0;
      load_start = 1'b0;
      load_len   = '0;
      load_valid = 1'b0;
      load_data  = '0;
   endtask

   logic [DATA_W-1:0] prog [4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};
   logic [ADDR_W-1:0] err_addr [3] = '{32'h2, 32'h200, 32'h4};

   initial begin
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      load_start = 1'b1;
      load_len   = 4;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1;
         load_data  = prog[i];
         tick();
      end
      load_valid = 1'b0;
      tick();
      tick();

      fetch_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         fetch_addr = ADDR_W'(i * 4);
         tick();
      end
      fetch_req = 1'b0;
      repeat (3) tick();

      fetch_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         fetch_addr = err_addr[i];
         tick();
      end
      fetch_req = 1'b0;
      repeat (3) tick();

      fetch_req  = 1'b1;
      fetch_addr = 32'h0;
      load_start = 1'b1;
      load_len   = 2;
      tick();
      load_start = 1'b0;
      load_valid = 1'b1;
      load_data  = $urandom;
      tick();
      load_valid = 1'b0;
      repeat (3) tick();
      load_valid = 1'b1;
      load_data  = $urandom;
      tick();
      load_valid = 1'b0;
      repeat (3) tick();
      fetch_req = 1'b0;
      tick();

      load_start = 1'b1;
      load_len   = 8;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1;
         load_data  = $urandom;
         tick();
      end
      load_data = $urandom;
      rst       = 1'b1;
      tick();
      rst        = 1'b0;
      load_valid = 1'b0;
      fetch_req  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         fetch_addr = ADDR_W'(i * 4);
         tick();
      end
      fetch_req = 1'b0;
      repeat (3) tick();

      load_start = 1'b1;
      load_len   = 0;
      tick();
      load_start = 1'b0;
      repeat (2) tick();

      load_start = 1'b1;
      load_len   = 255;
      tick();
      for (int n = 0; n < 1000 && m_loading; n++) begin
         load_start = ($urandom_range(0, 7) == 0);
         load_len   = (IDX_W + 1)'($urandom_range(0, 255));
         load_valid = ($urandom_range(0, 3) != 0);
         load_data  = $urandom;
         fetch_req  = $urandom_range(0, 1) == 1;
         fetch_addr = 32'h0;
         tick();
      end
      chk("clamp_load_busy", 64'(bus1.load_busy), 64'(0));
      idle();
      tick();

      for (int n = 0; n < 500; n++) begin
         fetch_req  = ($urandom_range(0, 3) != 0);
         fetch_addr = ADDR_W'($urandom_range(0, DEPTH * 4 + 63));
         load_start = ($urandom_range(0, 39) == 0);
         load_len   = (IDX_W + 1)'($urandom_range(0, 20));
         load_valid = ($urandom_range(0, 1) == 1);
         load_data  = $urandom;
         tick();
      end
      idle();
      repeat (4) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
